// File: rtl/te_trace_ctrl.sv
// Trace-control sequencer: enable/trigger FSM, per-retirement qualification,
// first/privchange indications, encoder enable/disable pulses and resync counter.
module te_trace_ctrl #(
  parameter int RESYNC_CNT_W = 16,
  parameter int PRIV_W       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    trace_enable_i,
  input  logic                    trigger_on_i,
  input  logic                    trigger_off_i,
  input  logic                    iretired_i,
  input  logic [PRIV_W-1:0]       priv_lvl_i,
  input  logic [PRIV_W-1:0]       priv_max_i,
  input  logic                    packet_emitted_i,
  input  logic [RESYNC_CNT_W-1:0] resync_max_i,
  output logic                    qualified_o,
  output logic                    first_qualified_o,
  output logic                    privchange_o,
  output logic                    enc_enabled_o,
  output logic                    enc_disabled_o,
  output logic                    gt_max_resync_o,
  output logic                    et_max_resync_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARMED = 2'd1,
    S_TRACE = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                  r_state, w_state_nxt;
  logic                    r_first_pending;
  logic                    r_entry;
  logic [RESYNC_CNT_W-1:0] r_resync_cnt;
  logic [PRIV_W-1:0]       r_last_priv;

  logic w_in_trace;
  logic w_start;
  logic w_qual;

  assign w_in_trace = (r_state == S_TRACE);
  assign w_qual     = w_in_trace & iretired_i & (priv_lvl_i <= priv_max_i);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_OFF:   if (trace_enable_i) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (!trace_enable_i) begin
          w_state_nxt = S_OFF;
        end else if (trigger_on_i && !trigger_off_i) begin
          w_state_nxt = S_TRACE;
          w_start     = 1'b1;
        end
      end
      S_TRACE: if (!trace_enable_i || trigger_off_i) w_state_nxt = S_STOP;
      S_STOP:  w_state_nxt = trace_enable_i ? S_ARMED : S_OFF;
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_OFF;
    else         r_state <= w_state_nxt;
  end

  // Pending flag masks privchange on the first qualified instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first_pending <= 1'b0;
      r_entry         <= 1'b0;
      r_last_priv     <= '1;
    end else begin
      r_entry <= w_start;
      if (w_start)     r_first_pending <= 1'b1;
      else if (w_qual) r_first_pending <= 1'b0;
      if (w_qual)      r_last_priv     <= priv_lvl_i;
    end
  end

  // A packet restarts the count; the qualifying instruction in that cycle counts as 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resync_cnt <= '0;
    end else if (w_start) begin
      r_resync_cnt <= '0;
    end else if (w_in_trace) begin
      if (packet_emitted_i)
        r_resync_cnt <= w_qual ? RESYNC_CNT_W'(1) : '0;
      else if (w_qual && !(&r_resync_cnt))
        r_resync_cnt <= r_resync_cnt + RESYNC_CNT_W'(1);
    end
  end

  assign qualified_o       = w_qual;
  assign first_qualified_o = w_qual & r_first_pending;
  assign privchange_o      = w_qual & ~r_first_pending & (priv_lvl_i != r_last_priv);
  assign enc_enabled_o     = w_in_trace & r_entry;
  assign enc_disabled_o    = (r_state == S_STOP);
  assign gt_max_resync_o   = (r_resync_cnt > resync_max_i);
  assign et_max_resync_o   = (r_resync_cnt == resync_max_i);
  assign state_o           = r_state;

endmodule

// File: tb/tb_te_trace_ctrl.sv
// Directed table-driven bench for te_trace_ctrl: one vector per cycle, inputs
// driven on the falling edge and all outputs compared shortly after.
module tb_te_trace_ctrl;

  typedef struct packed {
    logic        en, on, off, ir;
    logic [1:0]  pv, pm;
    logic        pk;
    logic [15:0] rm;
    logic [1:0]  st;
    logic        q, fq, pc, ee, ed, gt, et;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        trace_enable_i, trigger_on_i, trigger_off_i, iretired_i;
  logic [1:0]  priv_lvl_i, priv_max_i;
  logic        packet_emitted_i;
  logic [15:0] resync_max_i;
  logic        qualified_o, first_qualified_o, privchange_o;
  logic        enc_enabled_o, enc_disabled_o, gt_max_resync_o, et_max_resync_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  te_trace_ctrl #(.RESYNC_CNT_W(16), .PRIV_W(2)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .trace_enable_i    (trace_enable_i),
    .trigger_on_i      (trigger_on_i),
    .trigger_off_i     (trigger_off_i),
    .iretired_i        (iretired_i),
    .priv_lvl_i        (priv_lvl_i),
    .priv_max_i        (priv_max_i),
    .packet_emitted_i  (packet_emitted_i),
    .resync_max_i      (resync_max_i),
    .qualified_o       (qualified_o),
    .first_qualified_o (first_qualified_o),
    .privchange_o      (privchange_o),
    .enc_enabled_o     (enc_enabled_o),
    .enc_disabled_o    (enc_disabled_o),
    .gt_max_resync_o   (gt_max_resync_o),
    .et_max_resync_o   (et_max_resync_o),
    .state_o           (state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(int en, int on, int off, int ir, int pv, int pm, int pk, int rm,
                              int st, int q, int fq, int pc, int ee, int ed, int gt, int et);
    vec_t v;
    v.en = (en != 0); v.on = (on != 0); v.off = (off != 0); v.ir = (ir != 0);
    v.pv = 2'(pv);    v.pm = 2'(pm);    v.pk = (pk != 0);   v.rm = 16'(rm);
    v.st = 2'(st);    v.q = (q != 0);   v.fq = (fq != 0);   v.pc = (pc != 0);
    v.ee = (ee != 0); v.ed = (ed != 0); v.gt = (gt != 0);   v.et = (et != 0);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    trace_enable_i   = v.en;
    trigger_on_i     = v.on;
    trigger_off_i    = v.off;
    iretired_i       = v.ir;
    priv_lvl_i       = v.pv;
    priv_max_i       = v.pm;
    packet_emitted_i = v.pk;
    resync_max_i     = v.rm;
  endtask

  // Outputs packed as {st,q,fq,pc,ee,ed,gt,et}.
  task automatic check(input vec_t v, input string name);
    logic [8:0] act, exp;
    act = {state_o, qualified_o, first_qualified_o, privchange_o,
           enc_enabled_o, enc_disabled_o, gt_max_resync_o, et_max_resync_o};
    exp = {v.st, v.q, v.fq, v.pc, v.ee, v.ed, v.gt, v.et};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {st,q,fq,pc,ee,ed,gt,et}=%b_%b, expected %b_%b",
               name, act[8:7], act[6:0], exp[8:7], exp[6:0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v);
    #1;
    check(v, name);
  endtask

  vec_t tbl[29];
  vec_t post[4];

  initial begin
    //            en on of ir pv pm pk rm   st q fq pc ee ed gt et
    tbl[0]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 3, 3, 0, 15,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  3, 0, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 3, 3, 0, 15,  1, 0, 0, 0, 0, 0, 0, 0);
    // both triggers in ARMED: off wins
    tbl[9]  = mk(1, 1, 1, 0, 3, 3, 0, 15,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 3, 3, 0, 15,  1, 0, 0, 0, 0, 0, 0, 0);
    // privilege filter, priv_max=0; trigger_on in TRACE ignored at 12
    tbl[11] = mk(1, 0, 0, 1, 0, 0, 0, 15,  2, 1, 1, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 1, 3, 0, 0, 15,  2, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 0, 0, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 1, 1, 0, 0, 15,  2, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 1, 0, 0, 0, 0, 15,  2, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 15,  3, 0, 0, 0, 0, 1, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 0, 0, 0, 15,  1, 0, 0, 0, 0, 0, 0, 0);
    // privilege change 3,3,0,3 and resync with max=3
    tbl[18] = mk(1, 0, 0, 1, 3, 3, 0, 3,   2, 1, 1, 0, 1, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 1, 3, 3, 0, 3,   2, 1, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 1, 0, 3, 0, 3,   2, 1, 0, 1, 0, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 1, 3, 3, 0, 3,   2, 1, 0, 1, 0, 0, 0, 1);
    tbl[22] = mk(1, 0, 0, 1, 3, 3, 1, 3,   2, 1, 0, 0, 0, 0, 1, 0);
    tbl[23] = mk(1, 0, 0, 0, 3, 3, 0, 1,   2, 0, 0, 0, 0, 0, 0, 1);
    // count up to 5 for the reset-mid-trace sequence
    tbl[24] = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[25] = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(1, 0, 0, 1, 3, 3, 0, 15,  2, 1, 0, 0, 0, 0, 0, 0);
    tbl[28] = mk(1, 0, 0, 0, 3, 3, 0, 5,   2, 0, 0, 0, 0, 0, 0, 1);

    post[0] = mk(1, 0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    post[1] = mk(1, 1, 0, 0, 3, 3, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1);
    post[2] = mk(1, 0, 0, 1, 1, 3, 0, 0,   2, 1, 1, 0, 1, 0, 0, 1);
    post[3] = mk(1, 0, 0, 1, 1, 3, 0, 0,   2, 1, 0, 0, 0, 0, 1, 0);

    rst_ni = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    #3;
    check(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1), "reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 29; i++) begin
      @(negedge clk_i);
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset mid-trace with counter at 5
    #2;
    rst_ni = 1'b0;
    apply(mk(1, 0, 0, 1, 3, 3, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0), "async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply(post[0], "post_reset0");
    for (int i = 1; i < 4; i++) begin
      @(negedge clk_i);
      apply(post[i], $sformatf("post_reset%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
